// File: rtl/elevator_motor_seq.sv
// Car motor sequencer: tracks floor position from sensor ticks and drives motor enable,
// direction and a stepped speed ramp, with reversal dead time, tick watchdog and e-stop latch.
module elevator_motor_seq #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2,
    parameter int SPD_W    = 3,
    parameter int RAMP_DIV = 8,
    parameter int DEAD_CYC = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [FLOOR_W-1:0] cmd_floor,
    output logic               cmd_ready,
    input  logic               floor_tick,
    input  logic               estop,
    output logic               motor_onoff,
    output logic               motor_dir,
    output logic [SPD_W-1:0]   motor_speed,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               busy,
    output logic               arrived,
    output logic               fault
);

    localparam int RC_W = $clog2(RAMP_DIV + 1);
    localparam int DC_W = $clog2(DEAD_CYC + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [SPD_W-1:0]   SPD_MAX = '1;
    localparam logic [SPD_W-1:0]   SPD_PEN = SPD_MAX - 1'b1;
    localparam logic [FLOOR_W:0]   NF_L    = N_FLOORS[FLOOR_W:0];
    localparam logic [FLOOR_W-1:0] TOP_FL  = FLOOR_W'(N_FLOORS - 1);

    typedef enum logic [2:0] {S_IDLE, S_DEAD, S_ACCEL, S_RUN, S_DECEL, S_FAULT} state_t;

    state_t             state_q;
    logic [FLOOR_W-1:0] cur_floor_q, target_q;
    logic               dir_q, last_dir_q;
    logic               motor_onoff_q, motor_dir_q, busy_q, arrived_q, fault_q, cmd_ready_q;
    logic [SPD_W-1:0]   speed_q;
    logic [RC_W-1:0]    ramp_q;
    logic [DC_W-1:0]    dead_q;
    logic [WD_W-1:0]    wd_q;

    // Saturating one-floor step in the travel direction.
    function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] f, input logic up);
        if (up) return (f == TOP_FL) ? f : f + 1'b1;
        else    return (f == '0)     ? f : f - 1'b1;
    endfunction

    function automatic logic is_adjacent(input logic [FLOOR_W-1:0] a, input logic [FLOOR_W-1:0] b);
        return ({1'b0, a} == {1'b0, b} + 1'b1) || ({1'b0, b} == {1'b0, a} + 1'b1);
    endfunction

    logic               moving_d, go_fault_d, cmd_up_d, cmd_oob_d, near_d, ramp_end_d;
    logic [FLOOR_W-1:0] floor_nxt_d;

    always_comb begin
        moving_d    = (state_q == S_ACCEL) || (state_q == S_RUN) || (state_q == S_DECEL);
        floor_nxt_d = step_floor(cur_floor_q, dir_q);
        near_d      = is_adjacent(target_q, cur_floor_q);
        ramp_end_d  = (ramp_q == RC_W'(RAMP_DIV - 1));
        cmd_up_d    = (cmd_floor > cur_floor_q);
        cmd_oob_d   = ({1'b0, cmd_floor} >= NF_L);
        // A tick in the expiry cycle rescues the move; estop always wins.
        go_fault_d  = estop || (moving_d && !floor_tick && (wd_q == WD_W'(TIMEOUT - 1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cur_floor_q   <= '0;
            target_q      <= '0;
            dir_q         <= 1'b0;
            last_dir_q    <= 1'b0;
            motor_onoff_q <= 1'b0;
            motor_dir_q   <= 1'b0;
            speed_q       <= '0;
            busy_q        <= 1'b0;
            arrived_q     <= 1'b0;
            fault_q       <= 1'b0;
            cmd_ready_q   <= 1'b0;
            ramp_q        <= '0;
            dead_q        <= '0;
            wd_q          <= '0;
        end else begin
            arrived_q <= 1'b0;
            if (go_fault_d) begin
                state_q       <= S_FAULT;
                motor_onoff_q <= 1'b0;
                speed_q       <= '0;
                busy_q        <= 1'b0;
                fault_q       <= 1'b1;
                cmd_ready_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cmd_ready_q <= 1'b1;
                        if (cmd_valid && cmd_ready_q && !cmd_oob_d) begin
                            if (cmd_floor == cur_floor_q) begin
                                arrived_q <= 1'b1;
                            end else begin
                                target_q    <= cmd_floor;
                                dir_q       <= cmd_up_d;
                                busy_q      <= 1'b1;
                                cmd_ready_q <= 1'b0;
                                if (cmd_up_d != last_dir_q) begin
                                    state_q <= S_DEAD;
                                    dead_q  <= '0;
                                end else begin
                                    state_q       <= S_ACCEL;
                                    motor_onoff_q <= 1'b1;
                                    motor_dir_q   <= cmd_up_d;
                                    speed_q       <= SPD_W'(1);
                                    ramp_q        <= '0;
                                    wd_q          <= '0;
                                end
                            end
                        end
                    end
                    S_DEAD: begin
                        if (dead_q == DC_W'(DEAD_CYC - 1)) begin
                            state_q       <= S_ACCEL;
                            motor_onoff_q <= 1'b1;
                            motor_dir_q   <= dir_q;
                            speed_q       <= SPD_W'(1);
                            ramp_q        <= '0;
                            wd_q          <= '0;
                        end else begin
                            dead_q <= dead_q + 1'b1;
                        end
                    end
                    S_ACCEL, S_RUN, S_DECEL: begin
                        if (floor_tick) begin
                            cur_floor_q <= floor_nxt_d;
                            wd_q        <= '0;
                            if (floor_nxt_d == target_q) begin
                                state_q       <= S_IDLE;
                                motor_onoff_q <= 1'b0;
                                speed_q       <= '0;
                                arrived_q     <= 1'b1;
                                last_dir_q    <= dir_q;
                                busy_q        <= 1'b0;
                                cmd_ready_q   <= 1'b1;
                            end else if (state_q != S_DECEL && is_adjacent(target_q, floor_nxt_d)) begin
                                state_q <= S_DECEL;
                                ramp_q  <= '0;
                            end
                        end else begin
                            wd_q <= wd_q + 1'b1;
                            // A one-floor hop never leaves speed 1 while accelerating.
                            if ((state_q == S_ACCEL && !near_d) || state_q == S_DECEL) begin
                                if (ramp_end_d) begin
                                    ramp_q <= '0;
                                    if (state_q == S_ACCEL) begin
                                        speed_q <= speed_q + 1'b1;
                                        if (speed_q == SPD_PEN) state_q <= S_RUN;
                                    end else if (speed_q > SPD_W'(1)) begin
                                        speed_q <= speed_q - 1'b1;
                                    end
                                end else begin
                                    ramp_q <= ramp_q + 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign motor_onoff = motor_onoff_q;
    assign motor_dir   = motor_dir_q;
    assign motor_speed = speed_q;
    assign cur_floor   = cur_floor_q;
    assign busy        = busy_q;
    assign arrived     = arrived_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_elevator_motor_seq.sv
// Directed bench for elevator_motor_seq: multi-floor moves, reversal dead time, ramping,
// same-floor and out-of-range commands, watchdog fault, e-stop and asynchronous reset.
module tb_elevator_motor_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_floor = '0;
    logic       floor_tick = 1'b0;
    logic       estop = 1'b0;
    logic       cmd_ready, motor_onoff, motor_dir, busy, arrived, fault;
    logic [2:0] motor_speed;
    logic [1:0] cur_floor;

    logic       cmd_valid2 = 1'b0;
    logic [1:0] cmd_floor2 = '0;
    logic       cmd_ready2, motor_onoff2, motor_dir2, busy2, arrived2, fault2;
    logic [2:0] motor_speed2;
    logic [1:0] cur_floor2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    elevator_motor_seq dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_floor(cmd_floor), .cmd_ready(cmd_ready),
        .floor_tick(floor_tick), .estop(estop), .motor_onoff(motor_onoff), .motor_dir(motor_dir),
        .motor_speed(motor_speed), .cur_floor(cur_floor), .busy(busy), .arrived(arrived), .fault(fault)
    );

    // Three-floor instance so that a 2-bit floor code can be out of range.
    elevator_motor_seq #(.N_FLOORS(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_floor(cmd_floor2), .cmd_ready(cmd_ready2),
        .floor_tick(1'b0), .estop(1'b0), .motor_onoff(motor_onoff2), .motor_dir(motor_dir2),
        .motor_speed(motor_speed2), .cur_floor(cur_floor2), .busy(busy2), .arrived(arrived2), .fault(fault2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_once();
        floor_tick = 1'b1;
        step(1);
        floor_tick = 1'b0;
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst_onoff", 32'(motor_onoff), 0);
        chk("rst_speed", 32'(motor_speed), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_floor", 32'(cur_floor), 0);
        chk("rst_fault", 32'(fault), 0);
        rst = 1'b1;
        step(1);
        chk("idle_ready", 32'(cmd_ready), 1);

        // 1: floor 0 -> 2, reversal from last_dir=0 so DEAD first
        cmd_valid = 1'b1; cmd_floor = 2'd2;
        step(1);
        cmd_valid = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_ready", 32'(cmd_ready), 0);
        chk("t1_dead_on", 32'(motor_onoff), 0);
        step(15);
        chk("t1_dead_end", 32'(motor_onoff), 0);
        step(1);
        chk("t1_on", 32'(motor_onoff), 1);
        chk("t1_dir", 32'(motor_dir), 1);
        chk("t1_spd1", 32'(motor_speed), 1);
        step(7);
        chk("t1_spd1_hold", 32'(motor_speed), 1);
        step(1);
        chk("t1_spd2", 32'(motor_speed), 2);
        step(32);
        chk("t1_spd6", 32'(motor_speed), 6);
        step(8);
        chk("t1_spd7", 32'(motor_speed), 7);
        step(8);
        chk("t1_run_hold", 32'(motor_speed), 7);
        tick_once();
        chk("t1_floor1", 32'(cur_floor), 1);
        chk("t1_dec_start", 32'(motor_speed), 7);
        step(8);
        chk("t1_dec6", 32'(motor_speed), 6);
        step(40);
        chk("t1_dec1", 32'(motor_speed), 1);
        step(8);
        chk("t1_dec_floor", 32'(motor_speed), 1);
        chk("t1_still_on", 32'(motor_onoff), 1);
        tick_once();
        chk("t1_arrived", 32'(arrived), 1);
        chk("t1_off", 32'(motor_onoff), 0);
        chk("t1_spd0", 32'(motor_speed), 0);
        chk("t1_floor2", 32'(cur_floor), 2);
        chk("t1_idle", 32'(busy), 0);
        step(1);
        chk("t1_pulse_end", 32'(arrived), 0);

        // 2: floor 2 -> 3, same direction: no dead time, speed held at 1
        cmd_valid = 1'b1; cmd_floor = 2'd3;
        step(1);
        cmd_valid = 1'b0;
        chk("t2_on_n1", 32'(motor_onoff), 1);
        chk("t2_dir", 32'(motor_dir), 1);
        step(20);
        chk("t2_spd_hold", 32'(motor_speed), 1);
        tick_once();
        chk("t2_arrived", 32'(arrived), 1);
        chk("t2_floor3", 32'(cur_floor), 3);

        // 3: floor 3 -> 0, reversal
        step(1);
        cmd_valid = 1'b1; cmd_floor = 2'd0;
        step(1);
        cmd_valid = 1'b0;
        chk("t3_busy", 32'(busy), 1);
        step(15);
        chk("t3_dead_end", 32'(motor_onoff), 0);
        step(1);
        chk("t3_on", 32'(motor_onoff), 1);
        chk("t3_dir", 32'(motor_dir), 0);
        tick_once();
        chk("t3_floor2", 32'(cur_floor), 2);
        step(2);
        tick_once();
        chk("t3_floor1", 32'(cur_floor), 1);
        step(2);
        tick_once();
        chk("t3_floor0", 32'(cur_floor), 0);
        chk("t3_arrived", 32'(arrived), 1);
        chk("t3_off", 32'(motor_onoff), 0);

        // 4: same-floor command, and out-of-range on the 3-floor instance
        step(1);
        cmd_valid = 1'b1; cmd_floor = 2'd0;
        cmd_valid2 = 1'b1; cmd_floor2 = 2'd3;
        step(1);
        cmd_valid = 1'b0;
        chk("t4_same_arr", 32'(arrived), 1);
        chk("t4_same_off", 32'(motor_onoff), 0);
        chk("t4_same_busy", 32'(busy), 0);
        chk("t4_oob_busy", 32'(busy2), 0);
        chk("t4_oob_arr", 32'(arrived2), 0);
        chk("t4_oob_ready", 32'(cmd_ready2), 1);
        cmd_floor2 = 2'd2;
        step(1);
        cmd_valid2 = 1'b0;
        chk("t4_inrange_busy", 32'(busy2), 1);
        chk("t4_same_pulse_end", 32'(arrived), 0);

        // 5: 0 -> 1 (reversal vs last_dir=0), then starve the watchdog
        cmd_valid = 1'b1; cmd_floor = 2'd1;
        step(1);
        cmd_valid = 1'b0;
        chk("t5_dead", 32'(motor_onoff), 0);
        step(16);
        chk("t5_on", 32'(motor_onoff), 1);
        step(1023);
        chk("t5_pre_to", 32'(fault), 0);
        chk("t5_pre_to_on", 32'(motor_onoff), 1);
        step(1);
        chk("t5_fault", 32'(fault), 1);
        chk("t5_off", 32'(motor_onoff), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_floor = 2'd3;
        step(3);
        cmd_valid = 1'b0;
        chk("t5_no_accept", 32'(busy), 0);
        chk("t5_sticky", 32'(fault), 1);

        // 6: reset, move up into RUN, then estop together with a tick
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        chk("t6_cleared", 32'(fault), 0);
        cmd_valid = 1'b1; cmd_floor = 2'd3;
        step(1);
        cmd_valid = 1'b0;
        step(16);
        chk("t6_on", 32'(motor_onoff), 1);
        step(48);
        chk("t6_run", 32'(motor_speed), 7);
        tick_once();
        chk("t6_floor1", 32'(cur_floor), 1);
        step(4);
        floor_tick = 1'b1; estop = 1'b1;
        step(1);
        floor_tick = 1'b0; estop = 1'b0;
        chk("t6_fault", 32'(fault), 1);
        chk("t6_floor_hold", 32'(cur_floor), 1);
        chk("t6_off", 32'(motor_onoff), 0);
        chk("t6_spd0", 32'(motor_speed), 0);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_async_fault", 32'(fault), 0);
        chk("t6_async_floor", 32'(cur_floor), 0);
        chk("t6_async_busy", 32'(busy), 0);
        #20;
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
